// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] SAT_DIGIT = 4'd9;

endpackage

// File: rtl/bin2bcd_add3.sv
// Double-dabble digit cell: a BCD digit of 5 or more gets 3 added before the shift.
module bin2bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_i,
  output logic [BCD_W-1:0] digit_o
);

  always_comb begin
    case (digit_i)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: digit_o = digit_i;
      4'd5: digit_o = 4'd8;
      4'd6: digit_o = 4'd9;
      4'd7: digit_o = 4'd10;
      4'd8: digit_o = 4'd11;
      4'd9: digit_o = 4'd12;
      default: digit_o = digit_i;
    endcase
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock through a single row of add-3 cells.
// Optional leading-zero blank mask output is enabled by defining BIN2BCD_BLANK_EN.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         bin,
  output logic                     busy,
  output logic                     done,
  output logic [BCD_W*DIGITS-1:0]  bcd,
  output logic                     ovf
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]        blank
`endif
);

  localparam int SCR_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [SCR_W-1:0]     scratch_q, scratch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovfFlag_q, ovfFlag_d;
  logic [SCR_W-1:0]     bcd_q, bcd_d;
  logic                 ovf_q, ovf_d;
  logic [SCR_W-1:0]     adjusted;
  logic [SCR_W+WIDTH:0] shifted;
  logic                 lastShift;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_add3
    bin2bcd_add3 u_add3 (
      .digit_i(scratch_q[g*BCD_W +: BCD_W]),
      .digit_o(adjusted[g*BCD_W +: BCD_W])
    );
  end

  // Top bit of the shifted word is the carry out of the highest digit.
  assign shifted   = {adjusted, shift_q, 1'b0};
  assign lastShift = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (lastShift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  always_comb begin
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovfFlag_d = ovfFlag_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          ovfFlag_d = 1'b0;
        end
      end
      SHIFT: begin
        shift_d   = shifted[WIDTH-1:0];
        scratch_d = shifted[WIDTH +: SCR_W];
        cnt_d     = cnt_q - CNT_W'(1);
        ovfFlag_d = ovfFlag_q | shifted[SCR_W+WIDTH];
        // Results are published on the same edge that enters DONE.
        if (lastShift) begin
          ovf_d = ovfFlag_d;
          bcd_d = ovfFlag_d ? {DIGITS{SAT_DIGIT}} : scratch_d;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovfFlag_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovfFlag_q <= ovfFlag_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bcd = bcd_q;
  assign ovf = ovf_q;

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blankCalc;
  logic              zeroAbove;

  // A digit blanks only when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    zeroAbove = 1'b1;
    blankCalc = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zeroAbove    = zeroAbove & (scratch_d[i*BCD_W +: BCD_W] == '0);
      blankCalc[i] = zeroAbove;
    end
  end

  always_comb begin
    blank_d = blank_q;
    if (state_q == SHIFT && lastShift) begin
      blank_d = ovf_d ? '0 : blankCalc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`endif

endmodule
